packet_sched: RTL and testbench
===============================

# packet_sched

Buffer scheduler for the packet memory subsystem. Owns three `packet_ram` buffers (indices 0..2) and time-shares them among three agents: snooper (writes incoming packets), CPU (runs the BPF filter) and forwarder (drains accepted packets). The block grants buffers in strict arrival order. It drives buffer-select and length-reset controls that the packet memory wrapper uses to steer each agent's RAM port. It carries no packet data.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the accept and reject statistics counters.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sn_rdy`  out  1  snooper holds a buffer.
- `sn_sel`  out  2  buffer granted to the snooper.
- `sn_done`  in  1  pulse: packet fully written.
- `cpu_rdy`  out  1  CPU holds a buffer.
- `cpu_sel`  out  2  buffer granted to the CPU.
- `cpu_acc`  in  1  pulse: filter accepted the packet.
- `cpu_rej`  in  1  pulse: filter rejected the packet.
- `fwd_rdy`  out  1  forwarder holds a buffer.
- `fwd_sel`  out  2  buffer granted to the forwarder.
- `fwd_done`  in  1  pulse: packet fully drained.
- `len_rst`  out  3  one-hot, one-cycle pulse; connects to the `len_rst` input of the matching `packet_ram`.
- `acc_cnt`  out  CNT_WIDTH  number of accepted packets, wraps.
- `rej_cnt`  out  CNT_WIDTH  number of rejected packets, wraps.

## Operation
- Each buffer has a state: FREE, SNOOP, READY, CPU, ACCEPTED or FWD.
- Reset (async, any time, including mid-packet):
  - all buffers FREE;
  - pointers `sn_ptr`, `cpu_ptr`, `fwd_ptr` = 0;
  - every `*_rdy` = 0 and every `*_sel` = 0;
  - `len_rst` = 0;
  - counters = 0.
- Snooper grant:
  - Condition: `sn_rdy`=0 and buffer[`sn_ptr`] is FREE. Waiting strictly in ring order is intended, even if another buffer is FREE.
  - Action: buffer -> SNOOP, `sn_sel`=`sn_ptr`, `sn_rdy`=1, `len_rst[sn_ptr]` pulses high for 1 cycle.
- Snooper done:
  - `sn_done` while `sn_rdy`=1: buffer -> READY, `sn_rdy`=0, `sn_ptr` advances (mod 3).
- CPU grant:
  - Condition: `cpu_rdy`=0 and buffer[`cpu_ptr`] is READY.
  - Action: buffer -> CPU, `cpu_rdy`=1.
- CPU verdict (only while `cpu_rdy`=1):
  - `cpu_acc`: buffer -> ACCEPTED, `acc_cnt`+1.
  - `cpu_rej`: buffer -> FREE, `rej_cnt`+1.
  - If both are asserted in the same cycle, reject wins.
  - Either verdict: `cpu_rdy`=0 and `cpu_ptr` advances.
- Forwarder grant:
  - Scan from `fwd_ptr` in ring order; grant the first ACCEPTED buffer found.
  - Action: buffer -> FWD, `fwd_rdy`=1.
- Forwarder done:
  - `fwd_done` while `fwd_rdy`=1: buffer -> FREE, `fwd_rdy`=0, `fwd_ptr` = granted index + 1 (mod 3).
  - Rejected buffers are skipped by the scan.
- Pointer arithmetic: 2-bit wrap, 2 -> 0. Index value 3 is never produced.
- Done or verdict pulses received while the matching `*_rdy`=0 are ignored and do not change state.
- `*_sel` holds its last value while the matching `*_rdy`=0.

## Timing
- All outputs are registered.
- Grant latency: `*_rdy` rises on the first edge at which the grant condition holds.
- After a done or verdict edge, that agent's `*_rdy` stays low for at least 1 cycle.
- Throughput: a buffer freed at edge N can be granted to the snooper at edge N+1 at the earliest. The same one-edge lag applies to READY -> CPU and ACCEPTED -> FWD.
- Simultaneous events resolve within a single edge: `sn_done`, a CPU verdict and `fwd_done` on different buffers all update in the same cycle.
- Full condition: no buffer FREE, so `sn_rdy` stays 0. Upstream backpressure is the snooper's responsibility.
- Empty condition: no buffer READY or ACCEPTED, so `cpu_rdy` and `fwd_rdy` stay 0.

## Configuration
- `PACKET_SCHED_FWD_EN` defined: forwarder path exactly as described above.
- Not defined:
  - `cpu_acc` sends the buffer directly to FREE; the ACCEPTED and FWD states are unreachable.
  - `fwd_rdy` is tied to 0, `fwd_sel` is tied to 0, and `fwd_done` is ignored.
  - `acc_cnt` still counts.

## Structure
- `packet_sched_pkg` holds:
  - `NUM_BUFS`=3;
  - `buf_idx_t` (2-bit);
  - `buf_state_t` enum {FREE, SNOOP, READY, CPU, ACCEPTED, FWD};
  - the `ring_inc` function.
- One sub-module, `packet_sched_scan`: combinational first-match search of the buffer state vector from a start index, returning found/index. It is used by the forwarder grant.

## Test plan
- Reset, snooper `sn_done`, then `cpu_acc`, then `fwd_done` -> grants go to buffer 0 at each stage; `len_rst`=3'b001 for 1 cycle; `acc_cnt`=1; buffer 0 ends FREE.
- Snooper fills 0, 1, 2 with no CPU activity -> `sn_rdy` stays 0 after the third `sn_done`; first `cpu_acc` then `fwd_done` frees buffer 0 -> `sn_sel`=0 is granted one edge later.
- CPU verdicts reject 0, accept 1, accept 2 -> forwarder is granted 1 then 2; `rej_cnt`=1, `acc_cnt`=2.
- Same cycle: `sn_done` (buf 1), `cpu_rej` (buf 0) and a stray `fwd_done` while `fwd_rdy`=0 -> buf 1 READY, buf 0 FREE, forwarder state unchanged.
- `cpu_acc` and `cpu_rej` asserted together -> counted as reject only; with `PACKET_SCHED_FWD_EN` undefined, a lone `cpu_acc` frees the buffer and `fwd_rdy` stays 0.
- `rst_n` asserted while all three agents hold buffers -> every `*_rdy` goes 0 immediately, counters go 0, and after release the next snooper grant is buffer 0.

Source files
------------

// File: rtl/packet_sched_pkg.sv
// Shared types for the packet buffer scheduler: buffer indices, per-buffer
// ownership states and the 3-entry ring increment.
package packet_sched_pkg;

   localparam int NUM_BUFS = 3;

   typedef logic [1:0] buf_idx_t;

   typedef enum logic [2:0] {
      FREE,
      SNOOP,
      READY,
      CPU,
      ACCEPTED,
      FWD
   } buf_state_t;

   typedef buf_state_t [NUM_BUFS-1:0] buf_vec_t;

   // Wraps 2 -> 0; an out-of-range index also folds back to 0.
   function automatic buf_idx_t ring_inc(input buf_idx_t idx);
      return (idx >= buf_idx_t'(NUM_BUFS - 1)) ? buf_idx_t'(0) : idx + buf_idx_t'(1);
   endfunction

endpackage

// File: rtl/packet_sched_scan.sv
// Combinational first-match search over the buffer state vector, walking the
// ring from a start index and reporting the first buffer in match_state.
module packet_sched_scan
   import packet_sched_pkg::*;
(
   input  buf_vec_t   states,
   input  buf_idx_t   start,
   input  buf_state_t match_state,
   output logic       found,
   output buf_idx_t   idx
);

   buf_idx_t cand;

   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (!found && (states[cand] == match_state)) begin
            found = 1'b1;
            idx   = cand;
         end
         cand = ring_inc(cand);
      end
   end

endmodule

// File: rtl/packet_sched.sv
// Buffer scheduler time-sharing three packet_ram buffers among snooper, CPU and
// forwarder. Define PACKET_SCHED_FWD_EN to enable the forwarder path.
module packet_sched
   import packet_sched_pkg::*;
#(
   parameter int CNT_WIDTH = 16
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 sn_rdy,
   output logic [1:0]           sn_sel,
   input  logic                 sn_done,
   output logic                 cpu_rdy,
   output logic [1:0]           cpu_sel,
   input  logic                 cpu_acc,
   input  logic                 cpu_rej,
   output logic                 fwd_rdy,
   output logic [1:0]           fwd_sel,
   input  logic                 fwd_done,
   output logic [2:0]           len_rst,
   output logic [CNT_WIDTH-1:0] acc_cnt,
   output logic [CNT_WIDTH-1:0] rej_cnt
);

   buf_vec_t               bufs_q, bufs_d;
   buf_idx_t               sn_ptr_q, sn_ptr_d;
   buf_idx_t               cpu_ptr_q, cpu_ptr_d;
   buf_idx_t               fwd_ptr_q, fwd_ptr_d;
   logic                   sn_rdy_q, sn_rdy_d;
   buf_idx_t               sn_sel_q, sn_sel_d;
   logic                   cpu_rdy_q, cpu_rdy_d;
   buf_idx_t               cpu_sel_q, cpu_sel_d;
   logic                   fwd_rdy_q, fwd_rdy_d;
   buf_idx_t               fwd_sel_q, fwd_sel_d;
   logic [2:0]             len_rst_q, len_rst_d;
   logic [CNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
   logic [CNT_WIDTH-1:0]   rej_cnt_q, rej_cnt_d;

   logic                   scan_found;
   buf_idx_t               scan_idx;

`ifdef PACKET_SCHED_FWD_EN
   packet_sched_scan u_fwd_scan (
      .states      (bufs_q),
      .start       (fwd_ptr_q),
      .match_state (ACCEPTED),
      .found       (scan_found),
      .idx         (scan_idx)
   );
`else
   logic fwd_done_unused;
   assign fwd_done_unused = fwd_done;
   assign scan_found      = 1'b0;
   assign scan_idx        = '0;
`endif

   // Each agent only ever touches the buffer it owns or one in its grant state,
   // so the three updates below never collide on the same buffer.
   always_comb begin
      bufs_d    = bufs_q;
      sn_ptr_d  = sn_ptr_q;
      cpu_ptr_d = cpu_ptr_q;
      fwd_ptr_d = fwd_ptr_q;
      sn_rdy_d  = sn_rdy_q;
      sn_sel_d  = sn_sel_q;
      cpu_rdy_d = cpu_rdy_q;
      cpu_sel_d = cpu_sel_q;
      fwd_rdy_d = fwd_rdy_q;
      fwd_sel_d = fwd_sel_q;
      len_rst_d = 3'b000;
      acc_cnt_d = acc_cnt_q;
      rej_cnt_d = rej_cnt_q;

      if (sn_rdy_q) begin
         if (sn_done) begin
            bufs_d[sn_sel_q] = READY;
            sn_rdy_d         = 1'b0;
            sn_ptr_d         = ring_inc(sn_ptr_q);
         end
      end else if (bufs_q[sn_ptr_q] == FREE) begin
         bufs_d[sn_ptr_q]    = SNOOP;
         sn_sel_d            = sn_ptr_q;
         sn_rdy_d            = 1'b1;
         len_rst_d[sn_ptr_q] = 1'b1;
      end

      // Reject has priority when both verdicts arrive together.
      if (cpu_rdy_q) begin
         if (cpu_rej) begin
            bufs_d[cpu_sel_q] = FREE;
            rej_cnt_d         = rej_cnt_q + CNT_WIDTH'(1);
            cpu_rdy_d         = 1'b0;
            cpu_ptr_d         = ring_inc(cpu_ptr_q);
         end else if (cpu_acc) begin
`ifdef PACKET_SCHED_FWD_EN
            bufs_d[cpu_sel_q] = ACCEPTED;
`else
            bufs_d[cpu_sel_q] = FREE;
`endif
            acc_cnt_d         = acc_cnt_q + CNT_WIDTH'(1);
            cpu_rdy_d         = 1'b0;
            cpu_ptr_d         = ring_inc(cpu_ptr_q);
         end
      end else if (bufs_q[cpu_ptr_q] == READY) begin
         bufs_d[cpu_ptr_q] = CPU;
         cpu_sel_d         = cpu_ptr_q;
         cpu_rdy_d         = 1'b1;
      end

`ifdef PACKET_SCHED_FWD_EN
      if (fwd_rdy_q) begin
         if (fwd_done) begin
            bufs_d[fwd_sel_q] = FREE;
            fwd_rdy_d         = 1'b0;
            fwd_ptr_d         = ring_inc(fwd_sel_q);
         end
      end else if (scan_found) begin
         bufs_d[scan_idx] = FWD;
         fwd_sel_d        = scan_idx;
         fwd_rdy_d        = 1'b1;
      end
`else
      if (scan_found) begin
         fwd_sel_d = scan_idx;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            bufs_q[i] <= FREE;
         end
         sn_ptr_q  <= '0;
         cpu_ptr_q <= '0;
         fwd_ptr_q <= '0;
         sn_rdy_q  <= 1'b0;
         sn_sel_q  <= '0;
         cpu_rdy_q <= 1'b0;
         cpu_sel_q <= '0;
         fwd_rdy_q <= 1'b0;
         fwd_sel_q <= '0;
         len_rst_q <= 3'b000;
         acc_cnt_q <= '0;
         rej_cnt_q <= '0;
      end else begin
         bufs_q    <= bufs_d;
         sn_ptr_q  <= sn_ptr_d;
         cpu_ptr_q <= cpu_ptr_d;
         fwd_ptr_q <= fwd_ptr_d;
         sn_rdy_q  <= sn_rdy_d;
         sn_sel_q  <= sn_sel_d;
         cpu_rdy_q <= cpu_rdy_d;
         cpu_sel_q <= cpu_sel_d;
         fwd_rdy_q <= fwd_rdy_d;
         fwd_sel_q <= fwd_sel_d;
         len_rst_q <= len_rst_d;
         acc_cnt_q <= acc_cnt_d;
         rej_cnt_q <= rej_cnt_d;
      end
   end

   assign sn_rdy  = sn_rdy_q;
   assign sn_sel  = sn_sel_q;
   assign cpu_rdy = cpu_rdy_q;
   assign cpu_sel = cpu_sel_q;
   assign fwd_rdy = fwd_rdy_q;
   assign fwd_sel = fwd_sel_q;
   assign len_rst = len_rst_q;
   assign acc_cnt = acc_cnt_q;
   assign rej_cnt = rej_cnt_q;

endmodule

// File: tb/tb_packet_sched.sv
// Directed bench for packet_sched; expectations track the forwarder build
// selected by PACKET_SCHED_FWD_EN.
module tb_packet_sched;

   localparam int CW = 16;
`ifdef PACKET_SCHED_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sn_rdy, cpu_rdy, fwd_rdy;
   logic [1:0]    sn_sel, cpu_sel, fwd_sel;
   logic          sn_done, cpu_acc, cpu_rej, fwd_done;
   logic [2:0]    len_rst;
   logic [CW-1:0] acc_cnt, rej_cnt;

   int nChecks = 0;
   int nFails  = 0;

   packet_sched #(.CNT_WIDTH(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sn_rdy   (sn_rdy),
      .sn_sel   (sn_sel),
      .sn_done  (sn_done),
      .cpu_rdy  (cpu_rdy),
      .cpu_sel  (cpu_sel),
      .cpu_acc  (cpu_acc),
      .cpu_rej  (cpu_rej),
      .fwd_rdy  (fwd_rdy),
      .fwd_sel  (fwd_sel),
      .fwd_done (fwd_done),
      .len_rst  (len_rst),
      .acc_cnt  (acc_cnt),
      .rej_cnt  (rej_cnt)
   );

   always #5 clk = ~clk;

   // Outputs are observed 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic sd, input logic ca, input logic cr, input logic fd);
      sn_done  = sd;
      cpu_acc  = ca;
      cpu_rej  = cr;
      fwd_done = fd;
      tick();
      sn_done  = 1'b0;
      cpu_acc  = 1'b0;
      cpu_rej  = 1'b0;
      fwd_done = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag,
                           input logic e_snr, input logic [1:0] e_sns,
                           input logic e_cpr, input logic [1:0] e_cps,
                           input logic e_fwr, input logic [1:0] e_fws,
                           input logic [2:0] e_len, input int e_acc, input int e_rej);
      checkOutput({tag, ".sn_rdy"},  32'(sn_rdy),  32'(e_snr));
      checkOutput({tag, ".sn_sel"},  32'(sn_sel),  32'(e_sns));
      checkOutput({tag, ".cpu_rdy"}, 32'(cpu_rdy), 32'(e_cpr));
      checkOutput({tag, ".cpu_sel"}, 32'(cpu_sel), 32'(e_cps));
      checkOutput({tag, ".fwd_rdy"}, 32'(fwd_rdy), 32'(e_fwr));
      checkOutput({tag, ".fwd_sel"}, 32'(fwd_sel), 32'(e_fws));
      checkOutput({tag, ".len_rst"}, 32'(len_rst), 32'(e_len));
      checkOutput({tag, ".acc_cnt"}, 32'(acc_cnt), e_acc);
      checkOutput({tag, ".rej_cnt"}, 32'(rej_cnt), e_rej);
   endtask

   // Reset is checked shortly after assertion, before any clock edge.
   task automatic doReset(input string tag);
      rst_n = 1'b0;
      #2;
      checkAll(tag, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b1;
      sn_done  = 1'b0;
      cpu_acc  = 1'b0;
      cpu_rej  = 1'b0;
      fwd_done = 1'b0;
      #1;

      $display("[TB] single packet through all stages");
      doReset("rst0");
      tick();
      checkAll("a_sn_grant", 1, 2'd0, 0, 2'd0, 0, 2'd0, 3'b001, 0, 0);
      tick();
      checkOutput("a_len_pulse_end", 32'(len_rst), 32'd0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("a_sn_done_rdy", 32'(sn_rdy), 32'd0);
      checkOutput("a_cpu_lag", 32'(cpu_rdy), 32'd0);
      tick();
      checkAll("a_cpu_grant", 1, 2'd1, 1, 2'd0, 0, 2'd0, 3'b010, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkAll("a_cpu_acc", 1, 2'd1, 0, 2'd0, 0, 2'd0, 3'b000, 1, 0);
      tick();
      checkAll("a_fwd_grant", 1, 2'd1, 0, 2'd0, FWD_EN, 2'd0, 3'b000, 1, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("a_fwd_done", 32'(fwd_rdy), 32'd0);
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("a_ring2", 1, 2'd2, 1, 2'd1, 0, 2'd0, 3'b100, 1, 0);
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("a_wrap_buf0", 1, 2'd0, 1, 2'd1, 0, 2'd0, 3'b001, 1, 0);

      $display("[TB] ring full, then free buffer 0");
      doReset("rst1");
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("b_full", 0, 2'd2, 1, 2'd0, 0, 2'd0, 3'b000, 0, 0);
      tick();
      checkOutput("b_full_hold", 32'(sn_rdy), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkAll("b_acc0", 0, 2'd2, 0, 2'd0, 0, 2'd0, 3'b000, 1, 0);
      tick();
      checkAll("b_after_acc", !FWD_EN, (FWD_EN ? 2'd2 : 2'd0), 1, 2'd1,
               FWD_EN, 2'd0, (FWD_EN ? 3'b000 : 3'b001), 1, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("b_free_lag", 32'(sn_rdy), 32'(!FWD_EN));
      checkOutput("b_fwd_released", 32'(fwd_rdy), 32'd0);
      tick();
      checkAll("b_regrant0", 1, 2'd0, 1, 2'd1, 0, 2'd0,
               (FWD_EN ? 3'b001 : 3'b000), 1, 0);

      $display("[TB] reject 0, accept 1, accept 2");
      doReset("rst2");
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      checkAll("c_rej0", 0, 2'd2, 0, 2'd0, 0, 2'd0, 3'b000, 0, 1);
      tick();
      checkAll("c_regrant", 1, 2'd0, 1, 2'd1, 0, 2'd0, 3'b001, 0, 1);
      applyStimulus(0, 1, 0, 0);
      tick();
      checkAll("c_fwd1", 1, 2'd0, 1, 2'd2, FWD_EN, (FWD_EN ? 2'd1 : 2'd0), 3'b000, 1, 1);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("c_fwd1_done", 32'(fwd_rdy), 32'd0);
      tick();
      checkAll("c_fwd2", 1, 2'd0, 0, 2'd2, FWD_EN, (FWD_EN ? 2'd2 : 2'd0), 3'b000, 2, 1);

      $display("[TB] simultaneous events and verdict priority");
      doReset("rst3");
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 1, 1);
      checkAll("d_same_cycle", 0, 2'd1, 0, 2'd0, 0, 2'd0, 3'b000, 0, 1);
      tick();
      checkAll("d_next", 1, 2'd2, 1, 2'd1, 0, 2'd0, 3'b100, 0, 1);
      applyStimulus(0, 1, 1, 0);
      checkAll("e_both_verdicts", 1, 2'd2, 0, 2'd1, 0, 2'd0, 3'b000, 0, 2);
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("e_regrant", 1, 2'd0, 1, 2'd2, 0, 2'd0, 3'b001, 0, 2);
      applyStimulus(0, 1, 0, 0);
      tick();
      checkAll("e_lone_acc", 1, 2'd0, 0, 2'd2, FWD_EN, (FWD_EN ? 2'd2 : 2'd0), 3'b000, 1, 2);
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("e_buf2_owner", !FWD_EN, (FWD_EN ? 2'd1 : 2'd2), 1, 2'd0,
               FWD_EN, (FWD_EN ? 2'd2 : 2'd0), (FWD_EN ? 3'b000 : 3'b100), 1, 2);

      $display("[TB] reset while agents hold buffers");
      doReset("rst4");
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      applyStimulus(0, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0);
      tick();
      checkAll("f_all_held", 1, 2'd2, 1, 2'd1, FWD_EN, 2'd0, 3'b100, 1, 0);
      doReset("f_midreset");
      tick();
      checkAll("f_after_rst", 1, 2'd0, 0, 2'd0, 0, 2'd0, 3'b001, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
